// File: rtl/bus_pkg.sv
// Shared types for the system bus router: access sizes, master ids, pending-read record.
package bus_pkg;

    localparam int unsigned SLV_IDX_W = 3;

    typedef enum logic [2:0] {
        SIZE_B = 3'd1,
        SIZE_H = 3'd2,
        SIZE_W = 3'd4
    } size_t;

    typedef enum logic {
        MST_FETCH = 1'b0,
        MST_STBUF = 1'b1
    } master_e;

    typedef struct packed {
        logic                 valid;
        logic [SLV_IDX_W-1:0] slv_idx;
        logic [2:0]           size;
    } pend_t;

    function automatic logic size_valid(input logic [2:0] size);
        return (size == SIZE_B) || (size == SIZE_H) || (size == SIZE_W);
    endfunction

endpackage

// File: rtl/bus_addr_decoder.sv
// Base/mask address decoder: lowest-index matching region wins; offset is relative to its base.
module bus_addr_decoder
    import bus_pkg::*;
#(
    parameter int unsigned                      NUM_SLAVES = 2,
    parameter int unsigned                      ADDR_WIDTH = 32,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_BASE   = '0,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_MASK   = '0
)(
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic [NUM_SLAVES-1:0] hit_o,
    output logic [SLV_IDX_W-1:0]  idx_o,
    output logic [ADDR_WIDTH-1:0] offset_o,
    output logic                  miss_o
);

    logic found;

    always_comb begin
        hit_o    = '0;
        idx_o    = '0;
        offset_o = '0;
        found    = 1'b0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (!found && ((addr_i & SLV_MASK[i*ADDR_WIDTH +: ADDR_WIDTH])
                           == SLV_BASE[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
                found    = 1'b1;
                hit_o[i] = 1'b1;
                idx_o    = SLV_IDX_W'(i);
                offset_o = addr_i - SLV_BASE[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
        miss_o = !found;
    end

endmodule

// File: rtl/bus_router.sv
// System bus: fetch and store-buffer masters to NUM_SLAVES address-mapped slaves.
// Optional access-fault reporting is enabled by defining BUS_ACCESS_FAULT_EN.
module bus_router
    import bus_pkg::*;
#(
    parameter int unsigned                      NUM_SLAVES  = 2,
    parameter int unsigned                      ADDR_WIDTH  = 32,
    parameter int unsigned                      DATA_WIDTH  = 32,
    parameter int unsigned                      FETCH_WIDTH = 2,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_BASE    = {32'h0200_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_MASK    = {32'hFFFF_0000, 32'hFFFF_0000},
    localparam int unsigned                     RDATA_W     = 32*FETCH_WIDTH
)(
    input  logic                               clk,
    input  logic                               rst,
    input  logic [ADDR_WIDTH-1:0]              fetch_bus_addr,
    input  logic                               fetch_bus_read_req,
    output logic [RDATA_W-1:0]                 bus_fetch_data,
    output logic                               bus_fetch_read_ack,
    output logic                               bus_fetch_fault,
    input  logic [ADDR_WIDTH-1:0]              stbuf_bus_read_addr,
    input  logic [2:0]                         stbuf_bus_read_size,
    input  logic                               stbuf_bus_read_req,
    output logic [DATA_WIDTH-1:0]              bus_stbuf_data,
    output logic                               bus_stbuf_read_ack,
    output logic                               bus_stbuf_read_fault,
    input  logic [ADDR_WIDTH-1:0]              stbuf_bus_write_addr,
    input  logic [2:0]                         stbuf_bus_write_size,
    input  logic [DATA_WIDTH-1:0]              stbuf_bus_write_data,
    input  logic                               stbuf_bus_write_req,
    output logic                               bus_stbuf_write_ack,
    output logic                               bus_stbuf_write_fault,
    output logic [NUM_SLAVES*ADDR_WIDTH-1:0]   bus_slv_read_addr,
    output logic [NUM_SLAVES*3-1:0]            bus_slv_read_size,
    output logic [NUM_SLAVES-1:0]              bus_slv_rd,
    input  logic [NUM_SLAVES*RDATA_W-1:0]      slv_bus_data,
    output logic [NUM_SLAVES*ADDR_WIDTH-1:0]   bus_slv_write_addr,
    output logic [NUM_SLAVES*3-1:0]            bus_slv_write_size,
    output logic [NUM_SLAVES*DATA_WIDTH-1:0]   bus_slv_write_data,
    output logic [NUM_SLAVES-1:0]              bus_slv_wr
);

    logic [NUM_SLAVES-1:0] f_hit, sr_hit, sw_hit;
    logic [SLV_IDX_W-1:0]  f_idx, sr_idx, sw_idx;
    logic [ADDR_WIDTH-1:0] f_off, sr_off, sw_off;
    logic                  f_miss, sr_miss, sw_miss;

    bus_addr_decoder #(.NUM_SLAVES(NUM_SLAVES), .ADDR_WIDTH(ADDR_WIDTH),
                       .SLV_BASE(SLV_BASE), .SLV_MASK(SLV_MASK)) u_dec_fetch (
        .addr_i(fetch_bus_addr), .hit_o(f_hit), .idx_o(f_idx), .offset_o(f_off), .miss_o(f_miss)
    );

    bus_addr_decoder #(.NUM_SLAVES(NUM_SLAVES), .ADDR_WIDTH(ADDR_WIDTH),
                       .SLV_BASE(SLV_BASE), .SLV_MASK(SLV_MASK)) u_dec_stbuf_rd (
        .addr_i(stbuf_bus_read_addr), .hit_o(sr_hit), .idx_o(sr_idx), .offset_o(sr_off), .miss_o(sr_miss)
    );

    bus_addr_decoder #(.NUM_SLAVES(NUM_SLAVES), .ADDR_WIDTH(ADDR_WIDTH),
                       .SLV_BASE(SLV_BASE), .SLV_MASK(SLV_MASK)) u_dec_stbuf_wr (
        .addr_i(stbuf_bus_write_addr), .hit_o(sw_hit), .idx_o(sw_idx), .offset_o(sw_off), .miss_o(sw_miss)
    );

    logic stbuf_rd_ok, stbuf_wr_ok;

    master_e rr_ptr_q, rr_ptr_d;
    pend_t   pend_fetch_q, pend_fetch_d, pend_stbuf_q, pend_stbuf_d;
    logic    fetch_err_q, fetch_err_d, stbuf_err_q, stbuf_err_d;
    logic    wr_ack_q, wr_ack_d;

    logic                  conflict, fetch_grant, stbuf_grant;
    logic [NUM_SLAVES-1:0] fetch_rd_vec, stbuf_rd_vec;
    logic                  fetch_ack, stbuf_ack, write_ack;

    // Only a real slave collision needs arbitration; misses and bad sizes never reach a slave.
    assign conflict    = fetch_bus_read_req && stbuf_bus_read_req && stbuf_rd_ok &&
                         !f_miss && !sr_miss && (f_idx == sr_idx);
    assign fetch_grant = fetch_bus_read_req && !(conflict && rr_ptr_q == MST_STBUF);
    assign stbuf_grant = stbuf_bus_read_req && !(conflict && rr_ptr_q == MST_FETCH);

    assign fetch_rd_vec = (fetch_grant && !rst) ? f_hit : '0;
    assign stbuf_rd_vec = (stbuf_grant && stbuf_rd_ok && !rst) ? sr_hit : '0;
    assign bus_slv_rd   = fetch_rd_vec | stbuf_rd_vec;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (conflict)
            rr_ptr_d = (rr_ptr_q == MST_FETCH) ? MST_STBUF : MST_FETCH;

        pend_fetch_d.valid   = fetch_grant;
        pend_fetch_d.slv_idx = f_idx;
        pend_fetch_d.size    = SIZE_W;
        fetch_err_d          = f_miss;

        pend_stbuf_d.valid   = stbuf_grant;
        pend_stbuf_d.slv_idx = sr_idx;
        pend_stbuf_d.size    = stbuf_bus_read_size;
        stbuf_err_d          = sr_miss || !stbuf_rd_ok;

        wr_ack_d             = stbuf_bus_write_req;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q     <= MST_FETCH;
            pend_fetch_q <= '0;
            pend_stbuf_q <= '0;
            fetch_err_q  <= 1'b0;
            stbuf_err_q  <= 1'b0;
            wr_ack_q     <= 1'b0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            pend_fetch_q <= pend_fetch_d;
            pend_stbuf_q <= pend_stbuf_d;
            fetch_err_q  <= fetch_err_d;
            stbuf_err_q  <= stbuf_err_d;
            wr_ack_q     <= wr_ack_d;
        end
    end

    // Slave-side request channels: the read port follows whichever master owns the slave this cycle.
    always_comb begin
        bus_slv_read_addr  = '0;
        bus_slv_read_size  = '0;
        bus_slv_write_addr = '0;
        bus_slv_write_size = '0;
        bus_slv_write_data = '0;
        bus_slv_wr         = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (stbuf_rd_vec[i]) begin
                bus_slv_read_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = sr_off;
                bus_slv_read_size[i*3 +: 3]                   = stbuf_bus_read_size;
            end else begin
                bus_slv_read_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = f_off;
                bus_slv_read_size[i*3 +: 3]                   = pend_fetch_d.size;
            end
            if (sw_hit[i]) begin
                bus_slv_write_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = sw_off;
                bus_slv_write_size[i*3 +: 3]                   = stbuf_bus_write_size;
                bus_slv_write_data[i*DATA_WIDTH +: DATA_WIDTH] = stbuf_bus_write_data;
            end
            bus_slv_wr[i] = stbuf_bus_write_req && stbuf_wr_ok && !sw_miss &&
                            (sw_idx == SLV_IDX_W'(i)) && !rst;
        end
    end

    // Responses are forced quiet while rst is high, including the cycle reset is first seen.
    assign fetch_ack = pend_fetch_q.valid && !rst;
    assign stbuf_ack = pend_stbuf_q.valid && !rst;
    assign write_ack = wr_ack_q && !rst;

    assign bus_fetch_read_ack  = fetch_ack;
    assign bus_stbuf_read_ack  = stbuf_ack;
    assign bus_stbuf_write_ack = write_ack;

    logic [DATA_WIDTH-1:0] stbuf_raw, stbuf_mask;

    always_comb begin
        bus_fetch_data = '0;
        stbuf_raw      = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (fetch_ack && !fetch_err_q && pend_fetch_q.slv_idx == SLV_IDX_W'(i))
                bus_fetch_data = slv_bus_data[i*RDATA_W +: RDATA_W];
            if (stbuf_ack && !stbuf_err_q && pend_stbuf_q.slv_idx == SLV_IDX_W'(i))
                stbuf_raw = slv_bus_data[i*RDATA_W +: DATA_WIDTH];
        end
        case (pend_stbuf_q.size)
            SIZE_B:  stbuf_mask = DATA_WIDTH'(8'hFF);
            SIZE_H:  stbuf_mask = DATA_WIDTH'(16'hFFFF);
            default: stbuf_mask = '1;
        endcase
        bus_stbuf_data = stbuf_raw & stbuf_mask;
    end

`ifdef BUS_ACCESS_FAULT_EN
    logic wr_fault_q, wr_fault_d;

    assign stbuf_rd_ok = size_valid(stbuf_bus_read_size);
    assign stbuf_wr_ok = size_valid(stbuf_bus_write_size);
    assign wr_fault_d  = sw_miss || !stbuf_wr_ok;

    always_ff @(posedge clk) begin
        if (rst) wr_fault_q <= 1'b0;
        else     wr_fault_q <= wr_fault_d;
    end

    assign bus_fetch_fault       = fetch_ack && fetch_err_q;
    assign bus_stbuf_read_fault  = stbuf_ack && stbuf_err_q;
    assign bus_stbuf_write_fault = write_ack && wr_fault_q;
`else
    assign stbuf_rd_ok           = 1'b1;
    assign stbuf_wr_ok           = 1'b1;
    assign bus_fetch_fault       = 1'b0;
    assign bus_stbuf_read_fault  = 1'b0;
    assign bus_stbuf_write_fault = 1'b0;
`endif

endmodule

// File: tb/tb_bus_router.sv
// Directed self-checking bench for bus_router (default two-slave map: TCM @0x0, CLINT @0x0200_0000).
module tb_bus_router;

    localparam int unsigned NS = 2;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned RW = 64;

    logic           clk = 1'b0;
    logic           rst;
    logic [AW-1:0]  fetch_bus_addr;
    logic           fetch_bus_read_req;
    logic [RW-1:0]  bus_fetch_data;
    logic           bus_fetch_read_ack;
    logic           bus_fetch_fault;
    logic [AW-1:0]  stbuf_bus_read_addr;
    logic [2:0]     stbuf_bus_read_size;
    logic           stbuf_bus_read_req;
    logic [DW-1:0]  bus_stbuf_data;
    logic           bus_stbuf_read_ack;
    logic           bus_stbuf_read_fault;
    logic [AW-1:0]  stbuf_bus_write_addr;
    logic [2:0]     stbuf_bus_write_size;
    logic [DW-1:0]  stbuf_bus_write_data;
    logic           stbuf_bus_write_req;
    logic           bus_stbuf_write_ack;
    logic           bus_stbuf_write_fault;
    logic [NS*AW-1:0] bus_slv_read_addr;
    logic [NS*3-1:0]  bus_slv_read_size;
    logic [NS-1:0]    bus_slv_rd;
    logic [NS*RW-1:0] slv_bus_data;
    logic [NS*AW-1:0] bus_slv_write_addr;
    logic [NS*3-1:0]  bus_slv_write_size;
    logic [NS*DW-1:0] bus_slv_write_data;
    logic [NS-1:0]    bus_slv_wr;

    int checks   = 0;
    int failures = 0;

`ifdef BUS_ACCESS_FAULT_EN
    localparam logic EXP_FAULT = 1'b1;
`else
    localparam logic EXP_FAULT = 1'b0;
`endif

    bus_router #(.NUM_SLAVES(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FETCH_WIDTH(2)) dut (
        .clk(clk), .rst(rst),
        .fetch_bus_addr(fetch_bus_addr), .fetch_bus_read_req(fetch_bus_read_req),
        .bus_fetch_data(bus_fetch_data), .bus_fetch_read_ack(bus_fetch_read_ack),
        .bus_fetch_fault(bus_fetch_fault),
        .stbuf_bus_read_addr(stbuf_bus_read_addr), .stbuf_bus_read_size(stbuf_bus_read_size),
        .stbuf_bus_read_req(stbuf_bus_read_req), .bus_stbuf_data(bus_stbuf_data),
        .bus_stbuf_read_ack(bus_stbuf_read_ack), .bus_stbuf_read_fault(bus_stbuf_read_fault),
        .stbuf_bus_write_addr(stbuf_bus_write_addr), .stbuf_bus_write_size(stbuf_bus_write_size),
        .stbuf_bus_write_data(stbuf_bus_write_data), .stbuf_bus_write_req(stbuf_bus_write_req),
        .bus_stbuf_write_ack(bus_stbuf_write_ack), .bus_stbuf_write_fault(bus_stbuf_write_fault),
        .bus_slv_read_addr(bus_slv_read_addr), .bus_slv_read_size(bus_slv_read_size),
        .bus_slv_rd(bus_slv_rd), .slv_bus_data(slv_bus_data),
        .bus_slv_write_addr(bus_slv_write_addr), .bus_slv_write_size(bus_slv_write_size),
        .bus_slv_write_data(bus_slv_write_data), .bus_slv_wr(bus_slv_wr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        fetch_bus_read_req  = 1'b0;
        stbuf_bus_read_req  = 1'b0;
        stbuf_bus_write_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        fetch_bus_addr = '0; stbuf_bus_read_addr = '0; stbuf_bus_read_size = 3'd4;
        stbuf_bus_write_addr = '0; stbuf_bus_write_size = 3'd4; stbuf_bus_write_data = '0;
        slv_bus_data = '0;
        idle();
        repeat (2) step();

        // Reset state
        @(negedge clk);
        check("rst_fetch_ack", bus_fetch_read_ack, 1'b0);
        check("rst_stbuf_ack", bus_stbuf_read_ack, 1'b0);
        check("rst_write_ack", bus_stbuf_write_ack, 1'b0);
        check("rst_fetch_fault", bus_fetch_fault, 1'b0);
        check("rst_rd", bus_slv_rd, 2'b00);
        check("rst_wr", bus_slv_wr, 2'b00);
        step();
        rst = 1'b0;

        // 1: fetch from TCM+0x10
        fetch_bus_addr = 32'h0000_0010; fetch_bus_read_req = 1'b1;
        slv_bus_data[63:0] = 64'h0000_0013_0000_0093;
        @(negedge clk);
        check("t1_rd_N", bus_slv_rd, 2'b01);
        check("t1_addr0", bus_slv_read_addr[31:0], 32'h10);
        check("t1_ack_N", bus_fetch_read_ack, 1'b0);
        step(); idle();
        @(negedge clk);
        check("t1_ack", bus_fetch_read_ack, 1'b1);
        check("t1_data", bus_fetch_data, 64'h0000_0013_0000_0093);
        check("t1_rd_N1", bus_slv_rd, 2'b00);
        check("t1_fault", bus_fetch_fault, 1'b0);

        // 2: byte read from CLINT+0x8
        step();
        stbuf_bus_read_addr = 32'h0200_0008; stbuf_bus_read_size = 3'd1; stbuf_bus_read_req = 1'b1;
        slv_bus_data[127:64] = 64'h0000_0000_DEAD_BEEF;
        @(negedge clk);
        check("t2_rd_N", bus_slv_rd, 2'b10);
        check("t2_addr1", bus_slv_read_addr[63:32], 32'h8);
        check("t2_size1", bus_slv_read_size[5:3], 3'd1);
        step(); idle();
        @(negedge clk);
        check("t2_ack", bus_stbuf_read_ack, 1'b1);
        check("t2_data", bus_stbuf_data, 32'h0000_00EF);
        check("t2_fetch_ack", bus_fetch_read_ack, 1'b0);

        // 3: both masters hammer TCM; grants alternate F,S,F,S
        step();
        slv_bus_data[63:0] = 64'h1122_3344_5566_7788;
        fetch_bus_addr = 32'h0000_0000; fetch_bus_read_req = 1'b1;
        stbuf_bus_read_addr = 32'h0000_0004; stbuf_bus_read_size = 3'd4; stbuf_bus_read_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("t3_rd_c%0d", k), bus_slv_rd, 2'b01);
            check($sformatf("t3_addr0_c%0d", k), bus_slv_read_addr[31:0], (k % 2 == 0) ? 32'h0 : 32'h4);
            check($sformatf("t3_fack_c%0d", k), bus_fetch_read_ack, (k == 1 || k == 3));
            check($sformatf("t3_sack_c%0d", k), bus_stbuf_read_ack, (k == 2));
            if (k == 1) check("t3_fdata", bus_fetch_data, 64'h1122_3344_5566_7788);
            step();
        end
        idle();
        @(negedge clk);
        check("t3_fack_c4", bus_fetch_read_ack, 1'b0);
        check("t3_sack_c4", bus_stbuf_read_ack, 1'b1);
        check("t3_sdata", bus_stbuf_data, 32'h5566_7788);

        // 4: word write to CLINT+0x4
        step();
        stbuf_bus_write_addr = 32'h0200_0004; stbuf_bus_write_data = 32'h5;
        stbuf_bus_write_size = 3'd4; stbuf_bus_write_req = 1'b1;
        @(negedge clk);
        check("t4_wr_N", bus_slv_wr, 2'b10);
        check("t4_waddr1", bus_slv_write_addr[63:32], 32'h4);
        check("t4_wdata1", bus_slv_write_data[63:32], 32'h5);
        check("t4_rd_N", bus_slv_rd, 2'b00);
        step(); idle();
        @(negedge clk);
        check("t4_wack", bus_stbuf_write_ack, 1'b1);
        check("t4_sack", bus_stbuf_read_ack, 1'b0);
        check("t4_wr_N1", bus_slv_wr, 2'b00);
        check("t4_wfault", bus_stbuf_write_fault, 1'b0);

        // 5: unmapped reads from both masters
        step();
        fetch_bus_addr = 32'hFFFF_0000; fetch_bus_read_req = 1'b1;
        stbuf_bus_read_addr = 32'hFFFF_0000; stbuf_bus_read_size = 3'd4; stbuf_bus_read_req = 1'b1;
        @(negedge clk);
        check("t5_rd_N", bus_slv_rd, 2'b00);
        step(); idle();
        @(negedge clk);
        check("t5_fack", bus_fetch_read_ack, 1'b1);
        check("t5_fdata", bus_fetch_data, 64'h0);
        check("t5_ffault", bus_fetch_fault, EXP_FAULT);
        check("t5_sack", bus_stbuf_read_ack, 1'b1);
        check("t5_sdata", bus_stbuf_data, 32'h0);
        check("t5_sfault", bus_stbuf_read_fault, EXP_FAULT);

        // Different slaves in parallel
        step();
        fetch_bus_addr = 32'h0000_0008; fetch_bus_read_req = 1'b1;
        stbuf_bus_read_addr = 32'h0200_0000; stbuf_bus_read_size = 3'd2; stbuf_bus_read_req = 1'b1;
        @(negedge clk);
        check("par_rd", bus_slv_rd, 2'b11);
        check("par_addr0", bus_slv_read_addr[31:0], 32'h8);
        check("par_addr1", bus_slv_read_addr[63:32], 32'h0);
        step(); idle();
        @(negedge clk);
        check("par_fack", bus_fetch_read_ack, 1'b1);
        check("par_sack", bus_stbuf_read_ack, 1'b1);
        check("par_fdata", bus_fetch_data, 64'h1122_3344_5566_7788);
        check("par_sdata", bus_stbuf_data, 32'h0000_BEEF);

        // One conflict: fetch wins, pointer moves to stbuf
        step();
        fetch_bus_addr = 32'h0000_0000; fetch_bus_read_req = 1'b1;
        stbuf_bus_read_addr = 32'h0000_0004; stbuf_bus_read_size = 3'd4; stbuf_bus_read_req = 1'b1;
        @(negedge clk);
        check("pre_addr0", bus_slv_read_addr[31:0], 32'h0);
        step(); idle();
        @(negedge clk);
        check("pre_fack", bus_fetch_read_ack, 1'b1);
        check("pre_sack", bus_stbuf_read_ack, 1'b0);

        // 6: reset the cycle after a fetch request
        step();
        fetch_bus_addr = 32'h0000_0020; fetch_bus_read_req = 1'b1;
        @(negedge clk);
        check("t6_rd_N", bus_slv_rd, 2'b01);
        step();
        rst = 1'b1;
        @(negedge clk);
        check("t6_ack_rst1", bus_fetch_read_ack, 1'b0);
        check("t6_rd_rst1", bus_slv_rd, 2'b00);
        check("t6_data_rst1", bus_fetch_data, 64'h0);
        step();
        @(negedge clk);
        check("t6_ack_rst2", bus_fetch_read_ack, 1'b0);
        step();
        rst = 1'b0; idle();
        @(negedge clk);
        check("t6_ack_after", bus_fetch_read_ack, 1'b0);

        // Reset returns the round-robin pointer to fetch
        step();
        fetch_bus_addr = 32'h0000_0000; fetch_bus_read_req = 1'b1;
        stbuf_bus_read_addr = 32'h0000_0004; stbuf_bus_read_size = 3'd4; stbuf_bus_read_req = 1'b1;
        @(negedge clk);
        check("rr_rst_addr0", bus_slv_read_addr[31:0], 32'h0);
        check("rr_rst_rd", bus_slv_rd, 2'b01);
        step(); idle();
        @(negedge clk);
        check("rr_rst_fack", bus_fetch_read_ack, 1'b1);
        check("rr_rst_sack", bus_stbuf_read_ack, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
